// File: rtl/ec2_cpu_param.sv
// EC-2 accumulator machine: control FSM, accumulator datapath and a
// 2^ADDR_W x DATA_W program/data memory in one block. Instruction word is
// {opcode[2:0], ..., address[ADDR_W-1:0]}; ADDR_W must not exceed DATA_W-3.
module ec2_cpu_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Enter,
  input  logic [DATA_W-1:0] Input,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] Output,
  output logic              OutValid,
  output logic              Halt,
  output logic              Overflow,
  output logic [2:0]        state,
  output logic [ADDR_W-1:0] PC,
  output logic [2:0]        IR
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] IO_ADDR = '1;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_IN    = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_INWAIT = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t cur_st, nxt_st;

  logic [DATA_W-1:0]        mem [DEPTH];
  logic [DATA_W-1:0]        fetch_word;
  logic [DATA_W-1:0]        opnd_word;
  logic [ADDR_W-1:0]        opnd_addr;
  logic signed [DATA_W-1:0] acc;
  logic signed [DATA_W-1:0] opnd_s;
  logic signed [DATA_W-1:0] sum_r;
  logic signed [DATA_W-1:0] diff_r;
  logic                     armed;
  logic                     capture;
  logic                     store_mem;
  logic                     store_io;

  // Two's-complement overflow of A + B: equal operand signs, result sign flipped.
  function automatic logic add_ovf(input logic signed [DATA_W-1:0] a,
                                   input logic signed [DATA_W-1:0] b,
                                   input logic signed [DATA_W-1:0] r);
    return (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
  endfunction

  // Two's-complement overflow of A - B: differing operand signs, result sign flipped.
  function automatic logic sub_ovf(input logic signed [DATA_W-1:0] a,
                                   input logic signed [DATA_W-1:0] b,
                                   input logic signed [DATA_W-1:0] r);
    return (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
  endfunction

  assign fetch_word = mem[PC];
  assign opnd_word  = mem[opnd_addr];
  assign opnd_s     = $signed(opnd_word);
  assign sum_r      = acc + opnd_s;
  assign diff_r     = acc - opnd_s;
  assign state      = cur_st;
  assign Halt       = (cur_st == S_HALT);

  // State register; reset aborts whatever instruction is in flight.
  always_ff @(posedge Clock) begin
    if (Reset) cur_st <= S_FETCH;
    else       cur_st <= nxt_st;
  end

  // Next-state decode plus the per-state strobes used by datapath and memory.
  always_comb begin
    nxt_st    = cur_st;
    capture   = 1'b0;
    store_mem = 1'b0;
    store_io  = 1'b0;
    case (cur_st)
      S_FETCH:  nxt_st = S_DECODE;
      S_DECODE: begin
        if (IR == OP_HALT)    nxt_st = S_HALT;
        else if (IR == OP_IN) nxt_st = S_INWAIT;
        else                  nxt_st = S_EXEC;
      end
      S_EXEC: begin
        nxt_st = S_FETCH;
        if (IR == OP_STORE) begin
          if (opnd_addr == IO_ADDR) store_io  = 1'b1;
          else                      store_mem = 1'b1;
        end
      end
      S_INWAIT: begin
        if (Enter && armed) begin
          capture = 1'b1;
          nxt_st  = S_FETCH;
        end
      end
      S_HALT:   nxt_st = S_HALT;
      default:  nxt_st = S_FETCH;
    endcase
  end

  // Program counter, instruction latch, accumulator, output port and flags.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      PC       <= '0;
      IR       <= '0;
      acc      <= '0;
      Output   <= '0;
      OutValid <= 1'b0;
      Overflow <= 1'b0;
      armed    <= 1'b1;
    end else begin
      OutValid <= 1'b0;
      // Any cycle with Enter low re-arms the IN handshake.
      if (!Enter) armed <= 1'b1;
      if (capture) begin
        acc   <= $signed(Input);
        armed <= 1'b0;
      end
      case (cur_st)
        S_FETCH: begin
          opnd_addr <= fetch_word[ADDR_W-1:0];
          IR        <= fetch_word[DATA_W-1 -: 3];
          PC        <= PC + 1'b1;
        end
        S_EXEC: begin
          case (IR)
            OP_LOAD:  acc <= opnd_s;
            OP_STORE: begin
              if (store_io) begin
                Output   <= $unsigned(acc);
                OutValid <= 1'b1;
              end
            end
            OP_ADD: begin
              acc <= sum_r;
              if (add_ovf(acc, opnd_s, sum_r)) Overflow <= 1'b1;
            end
            OP_SUB: begin
              acc <= diff_r;
              if (sub_ovf(acc, opnd_s, diff_r)) Overflow <= 1'b1;
            end
            OP_JZ:    if (acc == '0) PC <= opnd_addr;
            OP_JPOS:  if (!acc[DATA_W-1] && (acc != '0)) PC <= opnd_addr;
            default:  ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Memory writes: program loading only while held in reset, STORE otherwise.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      if (prog_we) mem[prog_addr] <= prog_data;
    end else if (store_mem) begin
      mem[opnd_addr] <= $unsigned(acc);
    end
  end

endmodule

// File: tb/tb_ec2_cpu_param.sv
// Bench for ec2_cpu_param: directed scenarios plus random programs, checked
// cycle by cycle against an instruction-level model of the EC-2 machine.
module tb_ec2_cpu_param;

  localparam int DW   = 8;
  localparam int AW   = 5;
  localparam int MAXC = 200;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          Enter = 1'b0;
  logic [DW-1:0] Input = '0;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [DW-1:0] prog_data = '0;
  logic [DW-1:0] Output;
  logic          OutValid;
  logic          Halt;
  logic          Overflow;
  logic [2:0]    state;
  logic [AW-1:0] PC;
  logic [2:0]    IR;

  ec2_cpu_param #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .Clock(Clock), .Reset(Reset), .Enter(Enter), .Input(Input),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .Output(Output), .OutValid(OutValid), .Halt(Halt), .Overflow(Overflow),
    .state(state), .PC(PC), .IR(IR)
  );

  always #5 Clock = ~Clock;

  int n_chk  = 0;
  int n_pass = 0;

  logic [DW-1:0] shadow [32];
  logic [2:0]    e_st  [MAXC];
  logic [AW-1:0] e_pc  [MAXC];
  logic [2:0]    e_ir  [MAXC];
  logic [DW-1:0] e_out [MAXC];
  logic          e_vld [MAXC];
  logic          e_hlt [MAXC];
  logic          e_ovf [MAXC];
  int            cmp_len;
  int            dec_cnt [8];

  function automatic logic [7:0] ins(input logic [2:0] op, input logic [4:0] a);
    return {op, a};
  endfunction

  function automatic void set_exp(input int c, input logic [2:0] st, input logic [4:0] pc,
                                  input logic [2:0] ir, input logic [7:0] out,
                                  input logic vld, input logic hlt, input logic ovf);
    if (c < MAXC) begin
      e_st[c] = st; e_pc[c] = pc; e_ir[c] = ir; e_out[c] = out;
      e_vld[c] = vld; e_hlt[c] = hlt; e_ovf[c] = ovf;
    end
  endfunction

  // Instruction-level interpreter: every non-IN instruction spans three
  // cycles; effects appear from the first cycle of the next instruction.
  task automatic model_run(input int ncyc);
    logic [4:0] pc, npc, a;
    logic [7:0] acc, out, w, m;
    logic [2:0] op, prev;
    logic       ovf, vld;
    int         t, s;
    pc = '0; acc = '0; out = '0; ovf = 1'b0; vld = 1'b0; prev = '0; t = 0;
    cmp_len = ncyc;
    while (t < ncyc) begin
      w = shadow[pc]; op = w[7:5]; a = w[4:0]; npc = pc + 5'd1;
      set_exp(t, 3'd0, pc, prev, out, vld, 1'b0, ovf);
      set_exp(t + 1, 3'd1, npc, op, out, 1'b0, 1'b0, ovf);
      if (op == 3'b100) begin
        if (t + 2 < ncyc) cmp_len = t + 2;
        break;
      end
      if (op == 3'b111) begin
        for (int c = t + 2; c < ncyc; c++) set_exp(c, 3'd4, npc, op, out, 1'b0, 1'b1, ovf);
        break;
      end
      set_exp(t + 2, 3'd2, npc, op, out, 1'b0, 1'b0, ovf);
      m = shadow[a]; vld = 1'b0; pc = npc;
      case (op)
        3'b000: acc = m;
        3'b001: begin
          if (a == 5'd31) begin out = acc; vld = 1'b1; end
          else if (t + 3 < ncyc) shadow[a] = acc;
        end
        3'b010: begin
          s = int'($signed(acc)) + int'($signed(m));
          if (s > 127 || s < -128) ovf = 1'b1;
          acc = 8'(s);
        end
        3'b011: begin
          s = int'($signed(acc)) - int'($signed(m));
          if (s > 127 || s < -128) ovf = 1'b1;
          acc = 8'(s);
        end
        3'b101: if (acc == 8'd0) pc = a;
        3'b110: if ($signed(acc) > 8'sd0) pc = a;
        default: ;
      endcase
      prev = op;
      t += 3;
    end
  endtask

  task automatic begin_reset();
    Reset = 1'b1; prog_we = 1'b0; Enter = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
  endtask

  task automatic load_word(input logic [4:0] a, input logic [7:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d; shadow[a] = d;
    @(negedge Clock);
    prog_we = 1'b0;
  endtask

  // Release reset and compare every cycle against the model; prog_we is
  // hammered with junk throughout, which the DUT must ignore outside reset.
  task automatic run_prog(input int ncyc);
    model_run(ncyc);
    for (int k = 0; k < 8; k++) dec_cnt[k] = 0;
    Reset = 1'b0;
    for (int c = 0; c < cmp_len; c++) begin
      if (c > 0) @(negedge Clock);
      n_chk++; if (state !== e_st[c]) $display("FAIL state c=%0d got=%0d exp=%0d", c, state, e_st[c]); else n_pass++;
      n_chk++; if (PC !== e_pc[c]) $display("FAIL pc c=%0d got=%0d exp=%0d", c, PC, e_pc[c]); else n_pass++;
      n_chk++; if (IR !== e_ir[c]) $display("FAIL ir c=%0d got=%0d exp=%0d", c, IR, e_ir[c]); else n_pass++;
      n_chk++; if (Output !== e_out[c]) $display("FAIL output c=%0d got=%h exp=%h", c, Output, e_out[c]); else n_pass++;
      n_chk++; if (OutValid !== e_vld[c]) $display("FAIL outvalid c=%0d got=%b exp=%b", c, OutValid, e_vld[c]); else n_pass++;
      n_chk++; if (Halt !== e_hlt[c]) $display("FAIL halt c=%0d got=%b exp=%b", c, Halt, e_hlt[c]); else n_pass++;
      n_chk++; if (Overflow !== e_ovf[c]) $display("FAIL overflow c=%0d got=%b exp=%b", c, Overflow, e_ovf[c]); else n_pass++;
      if (state == 3'd1) dec_cnt[IR]++;
      prog_we = 1'b1; prog_addr = 5'($urandom); prog_data = 8'($urandom);
    end
  endtask

  task automatic test_reset();
    begin_reset();
    n_chk++; if (state !== 3'd0) $display("FAIL rst_state got=%0d exp=0", state); else n_pass++;
    n_chk++; if (PC !== 5'd0) $display("FAIL rst_pc got=%0d exp=0", PC); else n_pass++;
    n_chk++; if (IR !== 3'd0) $display("FAIL rst_ir got=%0d exp=0", IR); else n_pass++;
    n_chk++; if (Output !== 8'd0) $display("FAIL rst_output got=%h exp=00", Output); else n_pass++;
    n_chk++; if (OutValid !== 1'b0) $display("FAIL rst_outvalid got=%b exp=0", OutValid); else n_pass++;
    n_chk++; if (Halt !== 1'b0) $display("FAIL rst_halt got=%b exp=0", Halt); else n_pass++;
    n_chk++; if (Overflow !== 1'b0) $display("FAIL rst_overflow got=%b exp=0", Overflow); else n_pass++;
  endtask

  task automatic load_basic();
    load_word(5'd0, ins(3'b000, 5'd20));
    load_word(5'd1, ins(3'b010, 5'd21));
    load_word(5'd2, ins(3'b001, 5'd31));
    load_word(5'd3, ins(3'b111, 5'd0));
    load_word(5'd20, 8'd5);
    load_word(5'd21, 8'd7);
  endtask

  task automatic test_basic();
    begin_reset();
    load_basic();
    load_word(5'd31, 8'hA5);
    run_prog(16);
    n_chk++; if (Output !== 8'd12) $display("FAIL basic_output got=%h exp=0c", Output); else n_pass++;
    n_chk++; if (Halt !== 1'b1) $display("FAIL basic_halt got=%b exp=1", Halt); else n_pass++;
    begin_reset();
    load_word(5'd0, ins(3'b000, 5'd31));
    load_word(5'd1, ins(3'b001, 5'd31));
    load_word(5'd2, ins(3'b111, 5'd0));
    run_prog(12);
    n_chk++; if (Output !== 8'hA5) $display("FAIL io_mem_intact got=%h exp=a5", Output); else n_pass++;
  endtask

  task automatic test_overflow();
    begin_reset();
    load_word(5'd0, ins(3'b000, 5'd20));
    load_word(5'd1, ins(3'b010, 5'd21));
    load_word(5'd2, ins(3'b001, 5'd31));
    load_word(5'd3, ins(3'b011, 5'd22));
    load_word(5'd4, ins(3'b001, 5'd31));
    load_word(5'd5, ins(3'b111, 5'd0));
    load_word(5'd20, 8'h70);
    load_word(5'd21, 8'h20);
    load_word(5'd22, 8'h80);
    run_prog(22);
    n_chk++; if (Output !== 8'h10) $display("FAIL ovf_output got=%h exp=10", Output); else n_pass++;
    n_chk++; if (Overflow !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", Overflow); else n_pass++;
    begin_reset();
    n_chk++; if (Overflow !== 1'b0) $display("FAIL ovf_cleared got=%b exp=0", Overflow); else n_pass++;
  endtask

  task automatic test_handshake();
    int  k, pulses;
    logic seen;
    begin_reset();
    load_word(5'd0, ins(3'b100, 5'd0));
    load_word(5'd1, ins(3'b001, 5'd31));
    load_word(5'd2, ins(3'b100, 5'd0));
    load_word(5'd3, ins(3'b001, 5'd31));
    load_word(5'd4, ins(3'b111, 5'd0));
    Enter = 1'b1; Input = 8'h03;
    Reset = 1'b0;
    seen = 1'b0;
    for (k = 0; k < 20 && !seen; k++) begin
      @(negedge Clock);
      if (OutValid) seen = 1'b1;
    end
    n_chk++; if (!seen || Output !== 8'h03) $display("FAIL hs_first seen=%b got=%h exp=03", seen, Output); else n_pass++;
    n_chk++; if (k !== 6) $display("FAIL hs_first_latency got=%0d exp=6", k); else n_pass++;
    Input = 8'h55;
    pulses = 0;
    repeat (10) begin
      @(negedge Clock);
      if (OutValid) pulses++;
    end
    n_chk++; if (state !== 3'd3) $display("FAIL hs_wait_state got=%0d exp=3", state); else n_pass++;
    n_chk++; if (PC !== 5'd3) $display("FAIL hs_wait_pc got=%0d exp=3", PC); else n_pass++;
    n_chk++; if (pulses !== 0) $display("FAIL hs_no_capture got=%0d exp=0", pulses); else n_pass++;
    Enter = 1'b0; Input = 8'h09;
    @(negedge Clock);
    Enter = 1'b1;
    seen = 1'b0;
    for (k = 0; k < 10 && !seen; k++) begin
      @(negedge Clock);
      if (OutValid) seen = 1'b1;
    end
    n_chk++; if (!seen || Output !== 8'h09) $display("FAIL hs_second seen=%b got=%h exp=09", seen, Output); else n_pass++;
    begin_reset();
  endtask

  task automatic test_countdown();
    begin_reset();
    load_word(5'd0, ins(3'b000, 5'd20));
    load_word(5'd1, ins(3'b011, 5'd21));
    load_word(5'd2, ins(3'b101, 5'd4));
    load_word(5'd3, ins(3'b110, 5'd1));
    load_word(5'd4, ins(3'b001, 5'd31));
    load_word(5'd5, ins(3'b111, 5'd0));
    load_word(5'd20, 8'd3);
    load_word(5'd21, 8'd1);
    run_prog(40);
    n_chk++; if (dec_cnt[3] !== 3) $display("FAIL loop_body got=%0d exp=3", dec_cnt[3]); else n_pass++;
    n_chk++; if (dec_cnt[6] !== 2) $display("FAIL jpos_count got=%0d exp=2", dec_cnt[6]); else n_pass++;
    n_chk++; if (Output !== 8'd0) $display("FAIL loop_output got=%h exp=00", Output); else n_pass++;
    n_chk++; if (Halt !== 1'b1) $display("FAIL loop_halt got=%b exp=1", Halt); else n_pass++;
  endtask

  task automatic test_pc_wrap();
    begin_reset();
    load_word(5'd0, ins(3'b101, 5'd28));
    load_word(5'd1, ins(3'b001, 5'd31));
    load_word(5'd2, ins(3'b111, 5'd0));
    load_word(5'd28, ins(3'b000, 5'd20));
    load_word(5'd29, ins(3'b110, 5'd31));
    load_word(5'd31, ins(3'b000, 5'd21));
    load_word(5'd20, 8'd4);
    load_word(5'd21, 8'd5);
    run_prog(26);
    n_chk++; if (Output !== 8'd5) $display("FAIL wrap_output got=%h exp=05", Output); else n_pass++;
  endtask

  task automatic test_reset_store();
    begin_reset();
    load_basic();
    Reset = 1'b0;
    repeat (8) @(negedge Clock);
    n_chk++; if (state !== 3'd2 || IR !== 3'b001) $display("FAIL rs_exec got_state=%0d got_ir=%0d exp=2/1", state, IR); else n_pass++;
    Reset = 1'b1;
    @(negedge Clock);
    n_chk++; if (OutValid !== 1'b0) $display("FAIL rs_outvalid got=%b exp=0", OutValid); else n_pass++;
    n_chk++; if (Output !== 8'd0) $display("FAIL rs_output got=%h exp=00", Output); else n_pass++;
    n_chk++; if (PC !== 5'd0) $display("FAIL rs_pc got=%0d exp=0", PC); else n_pass++;
    n_chk++; if (state !== 3'd0) $display("FAIL rs_state got=%0d exp=0", state); else n_pass++;
    @(negedge Clock);
    run_prog(16);
    n_chk++; if (Output !== 8'd12) $display("FAIL rs_rerun got=%h exp=0c", Output); else n_pass++;
  endtask

  task automatic test_random();
    logic [2:0] op;
    repeat (20) begin
      begin_reset();
      for (int a = 0; a < 32; a++) begin
        op = 3'($urandom_range(0, 6));
        if (op >= 3'd4) op = op + 3'd1;
        load_word(5'(a), {op, 5'($urandom)});
      end
      run_prog(120);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_handshake();
    test_countdown();
    test_pc_wrap();
    test_reset_store();
    test_random();
    begin_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ec2_cpu_param.md
# ec2_cpu_param

Parametrised, single-module successor to the EC-2 accumulator microprocessor: control unit, datapath and program/data memory in one block. It executes the 8-instruction EC-2 ISA on a DATA_W-bit accumulator with 2^ADDR_W words of internal memory. New relative to the fixed 8-bit machine: width/depth parameters, a memory-mapped output port with a valid strobe, an edge-qualified Enter handshake, a sticky signed-overflow flag, and a memory-load port active during reset.

## Interface
- DATA_W, 8, accumulator/memory word width; instruction = opcode in bits [DATA_W-1:DATA_W-3], address in bits [ADDR_W-1:0]
- ADDR_W, 5, memory address width; legal range ADDR_W ≤ DATA_W-3; IO_ADDR = 2^ADDR_W-1

Ports:
- Clock  in  1  single clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high
- Enter  in  1  input-ready handshake for IN
- Input  in  DATA_W  data captured by IN
- prog_we  in  1  memory write enable, honoured only while Reset=1
- prog_addr  in  ADDR_W  program-load address
- prog_data  in  DATA_W  program-load data
- Output  out  DATA_W  output register, written by STORE to IO_ADDR
- OutValid  out  1  one-cycle pulse when Output is written
- Halt  out  1  high while in HALT
- Overflow  out  1  sticky signed overflow from ADD/SUB
- state  out  3  current FSM state
- PC  out  ADDR_W  program counter
- IR  out  3  current opcode

## Operation
- Memory: 2^ADDR_W × DATA_W register array, asynchronous read, synchronous write; not cleared by Reset.
- Opcodes: 000 LOAD A←M[a]; 001 STORE M[a]←A (a=IO_ADDR: Output←A, OutValid=1, memory unchanged); 010 ADD A←A+M[a]; 011 SUB A←A−M[a]; 100 IN A←Input; 101 JZ if A==0 PC←a; 110 JPOS if A≠0 and A[DATA_W-1]=0 then PC←a; 111 HALT.
- LOAD from IO_ADDR returns the memory word, not Output.
- Arithmetic: modulo 2^DATA_W. Overflow is set when the operands have signs that make two's-complement overflow possible (ADD: same signs; SUB: different signs) and the result sign differs from A's sign. Overflow stays set until Reset.
- FSM states: FETCH=0, DECODE=1, EXEC=2, INWAIT=3, HALT=4.
  - FETCH: latch instruction word, PC←PC+1, wrapping 2^ADDR_W-1→0; go to DECODE.
  - DECODE: IR valid. Opcode 111 → HALT. Opcode 100 → INWAIT. All other opcodes → EXEC.
  - EXEC: perform the op, then go to FETCH.
  - INWAIT: stay until Enter=1 and armed=1. On that cycle A←Input, clear armed, go to FETCH.
  - HALT: absorbing until Reset.
- Enter edge qualification: internal armed flag is set by any cycle with Enter=0 and cleared on capture. Holding Enter high across two consecutive IN instructions captures only once; the second IN waits for Enter to go low, then high again.
- Reset (Reset=1 at an edge) takes priority over everything and aborts any instruction in flight; a STORE in EXEC at that edge does not write. prog_we writes still occur while Reset=1.

## Timing
- Reset values: state=FETCH, PC=0, IR=0, A=0, Output=0, OutValid=0, Halt=0, Overflow=0, armed=1.
- Non-IN instructions take 3 cycles (FETCH, DECODE, EXEC).
- IN takes 2 + wait cycles; minimum 3 cycles if Enter is already high and armed.
- HALT is reached in 2 cycles; Halt asserts in the cycle after DECODE.
- Results are visible the cycle after EXEC: A, Output and Overflow update at the EXEC edge.
- OutValid is high exactly the one cycle following the STORE-IO EXEC edge.
- Taken jumps: the next FETCH uses the new PC. Not-taken jumps: PC is unchanged in EXEC.
- Control flags are all registered; outputs are registered except Halt, which is decoded from state.

## Test plan
- Load via prog port with DATA_W=8, ADDR_W=5: M0=LOAD 20, M1=ADD 21, M2=STORE 31, M3=HALT; M20=5, M21=7. Release Reset → Output=12, OutValid single pulse at cycle 9, Halt=1 from cycle 11, M31 unchanged.
- Overflow: M20=0x70, M21=0x20, ADD → A=0x90, Overflow=1. A later SUB producing 0x10 leaves Overflow=1 until Reset.
- Handshake: two consecutive IN with Enter held high, Input=0x03 → first IN captures 0x03; the second waits. Drop Enter, raise it with Input=0x09 → A=0x09.
- Countdown loop: A=3, loop SUB one / JZ exit / JPOS loop; store at exit → Output=0, loop body executed 3 times, JPOS not taken at A=0.
- PC wrap: JPOS to 31, where M31=LOAD x with positive data → PC wraps to 0 and fetches M0.
- Reset during the EXEC of STORE 31 → no OutValid, Output=0, PC=0, program memory intact; rerun produces the expected result.
